dff_pipe_bank: RTL and testbench

//  Parametrised register pipeline built on the library flop cells: WIDTH-bit data through DEPTH stages.
//  Per-stage valid bits, valid/ready backpressure with bubble collapsing, synchronous flush, occupancy count.

---
 rtl/dff_pipe_bank.sv | 95 +++++++++
 tb/tb_dff_pipe_bank.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/dff_pipe_bank.sv
// dff_pipe_bank: WIDTH x DEPTH stallable register pipeline with valid/ready, bubble collapsing, flush and occupancy count.
// Optional scan chain over the data registers when DFF_PIPE_BANK_SCAN_EN is defined.
module dff_pipe_bank #(
    parameter int               WIDTH     = 8,
    parameter int               DEPTH     = 3,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                         CK,
    input  logic                         RN,
    input  logic [WIDTH-1:0]             D,
    input  logic                         IN_VALID,
    output logic                         IN_READY,
    output logic [WIDTH-1:0]             Q,
    output logic                         OUT_VALID,
    input  logic                         OUT_READY,
    input  logic                         FLUSH,
`ifdef DFF_PIPE_BANK_SCAN_EN
    input  logic                         SE,
    input  logic                         SI,
    output logic                         SO,
`endif
    output logic [$clog2(DEPTH+1)-1:0]   COUNT
);
    localparam int CW = $clog2(DEPTH+1);

    logic [DEPTH-1:0]            v_q, v_d, adv, v_in;
    logic [DEPTH-1:0][WIDTH-1:0] r_q, r_d, r_in;
    logic                        scan, acc;

`ifdef DFF_PIPE_BANK_SCAN_EN
    // The packed bank is already in chain order: R[0][0] is bit 0, R[DEPTH-1][WIDTH-1] is the top bit.
    logic [WIDTH*DEPTH:0] sh;
    assign sh   = {r_q, SI};
    assign scan = SE;
    assign SO   = sh[WIDTH*DEPTH];
`else
    assign scan = 1'b0;
`endif

    // A stage advances if it or any stage closer to the output is empty, or the output drains.
    always_comb begin
        acc = OUT_READY;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            acc    = acc | !v_q[i];
            adv[i] = acc;
        end
    end

    always_comb begin
        v_in[0] = IN_VALID;
        r_in[0] = D;
        for (int i = 1; i < DEPTH; i++) begin
            v_in[i] = v_q[i-1];
            r_in[i] = r_q[i-1];
        end
    end

    always_comb begin
        v_d = v_q;
        r_d = r_q;
        if (scan) begin
`ifdef DFF_PIPE_BANK_SCAN_EN
            r_d = sh[WIDTH*DEPTH-1:0];
`endif
        end else if (FLUSH) begin
            v_d = '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (adv[i]) begin
                    v_d[i] = v_in[i];
                    if (v_in[i]) r_d[i] = r_in[i];
                end
            end
        end
    end

    always_ff @(posedge CK) begin
        if (!RN) begin
            v_q <= '0;
            r_q <= {DEPTH{RESET_VAL}};
        end else begin
            v_q <= v_d;
            r_q <= r_d;
        end
    end

    always_comb begin
        COUNT = '0;
        for (int i = 0; i < DEPTH; i++) COUNT = COUNT + CW'(v_q[i]);
    end

    assign IN_READY  = adv[0] & !scan;
    assign OUT_VALID = v_q[DEPTH-1] & !scan;
    assign Q         = r_q[DEPTH-1];
endmodule

// File: tb/tb_dff_pipe_bank.sv
// tb_dff_pipe_bank: directed checks of reset, streaming, backpressure, bubble collapse, flush/reset and scan.
module tb_dff_pipe_bank;
    logic       CK = 1'b0;
    logic       RN = 1'b0;
    logic [7:0] D = '0;
    logic       IN_VALID = 1'b0;
    logic       IN_READY;
    logic [7:0] Q;
    logic       OUT_VALID;
    logic       OUT_READY = 1'b0;
    logic       FLUSH = 1'b0;
    logic [1:0] COUNT;
`ifdef DFF_PIPE_BANK_SCAN_EN
    logic       SE = 1'b0;
    logic       SI = 1'b0;
    logic       SO;
`endif
    int tests = 0;
    int fails = 0;

    dff_pipe_bank #(.WIDTH(8), .DEPTH(3), .RESET_VAL(8'hA5)) dut (
        .CK(CK), .RN(RN), .D(D), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .Q(Q), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .FLUSH(FLUSH),
`ifdef DFF_PIPE_BANK_SCAN_EN
        .SE(SE), .SI(SI), .SO(SO),
`endif
        .COUNT(COUNT)
    );

    always #5 CK = ~CK;

    task automatic tick();
        @(posedge CK);
        #1;
    endtask

    task automatic test_reset();
        RN = 1'b0;
        tick();
        RN = 1'b1;
        #1;
        tests++; if (Q !== 8'hA5) begin fails++; $display("FAIL reset_q: got %h expected a5", Q); end
        tests++; if (OUT_VALID !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b expected 0", OUT_VALID); end
        tests++; if (IN_READY !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b expected 1", IN_READY); end
        tests++; if (COUNT !== 2'd0) begin fails++; $display("FAIL reset_count: got %0d expected 0", COUNT); end
    endtask

    task automatic test_streaming();
        logic       ev;
        logic [7:0] eq;
        OUT_READY = 1'b1;
        for (int c = 0; c < 8; c++) begin
            IN_VALID = (c < 4);
            D = 8'(c + 1);
            #1;
            tests++; if (IN_READY !== 1'b1) begin fails++; $display("FAIL stream_in_ready c=%0d: got %b expected 1", c, IN_READY); end
            tick();
            ev = (c + 1 >= 3) && (c + 1 <= 6);
            eq = 8'(c - 1);
            tests++; if (OUT_VALID !== ev) begin fails++; $display("FAIL stream_out_valid e=%0d: got %b expected %b", c + 1, OUT_VALID, ev); end
            if (ev) begin
                tests++; if (Q !== eq) begin fails++; $display("FAIL stream_q e=%0d: got %h expected %h", c + 1, Q, eq); end
            end
        end
        IN_VALID = 1'b0;
        tests++; if (COUNT !== 2'd0) begin fails++; $display("FAIL stream_drained_count: got %0d expected 0", COUNT); end
    endtask

    task automatic test_backpressure();
        OUT_READY = 1'b0;
        IN_VALID = 1'b1;
        D = 8'h10;
        #1;
        tests++; if (IN_READY !== 1'b1) begin fails++; $display("FAIL bp_first_ready: got %b expected 1", IN_READY); end
        tick();
        D = 8'h11; tick();
        D = 8'h12; tick();
        D = 8'h13;
        #1;
        tests++; if (IN_READY !== 1'b0) begin fails++; $display("FAIL bp_full_ready: got %b expected 0", IN_READY); end
        tests++; if (COUNT !== 2'd3) begin fails++; $display("FAIL bp_full_count: got %0d expected 3", COUNT); end
        tests++; if (OUT_VALID !== 1'b1 || Q !== 8'h10) begin fails++; $display("FAIL bp_full_head: got v=%b q=%h expected v=1 q=10", OUT_VALID, Q); end
        tick();
        tests++; if (COUNT !== 2'd3 || Q !== 8'h10) begin fails++; $display("FAIL bp_hold: got count=%0d q=%h expected 3 10", COUNT, Q); end
        OUT_READY = 1'b1;
        #1;
        tests++; if (IN_READY !== 1'b1) begin fails++; $display("FAIL bp_release_ready: got %b expected 1", IN_READY); end
        tick();
        IN_VALID = 1'b0;
        tests++; if (COUNT !== 2'd3 || Q !== 8'h11) begin fails++; $display("FAIL bp_swap: got count=%0d q=%h expected 3 11", COUNT, Q); end
        tick();
        tests++; if (OUT_VALID !== 1'b1 || Q !== 8'h12) begin fails++; $display("FAIL bp_drain_12: got v=%b q=%h expected v=1 q=12", OUT_VALID, Q); end
        tick();
        tests++; if (OUT_VALID !== 1'b1 || Q !== 8'h13) begin fails++; $display("FAIL bp_drain_13: got v=%b q=%h expected v=1 q=13", OUT_VALID, Q); end
        tick();
        tests++; if (OUT_VALID !== 1'b0 || COUNT !== 2'd0) begin fails++; $display("FAIL bp_empty: got v=%b count=%0d expected v=0 count=0", OUT_VALID, COUNT); end
    endtask

    task automatic test_bubble_flush();
        OUT_READY = 1'b0;
        IN_VALID = 1'b1; D = 8'h11; tick();
        IN_VALID = 1'b0; tick();
        IN_VALID = 1'b1; D = 8'h22; tick();
        IN_VALID = 1'b0; tick();
        tests++; if (COUNT !== 2'd2) begin fails++; $display("FAIL bubble_count: got %0d expected 2", COUNT); end
        tests++; if (OUT_VALID !== 1'b1 || Q !== 8'h11) begin fails++; $display("FAIL bubble_head: got v=%b q=%h expected v=1 q=11", OUT_VALID, Q); end
        tests++; if (IN_READY !== 1'b1) begin fails++; $display("FAIL bubble_ready: got %b expected 1", IN_READY); end
        FLUSH = 1'b1; IN_VALID = 1'b1; D = 8'h33;
        #1;
        tests++; if (IN_READY !== 1'b1) begin fails++; $display("FAIL flush_ready: got %b expected 1", IN_READY); end
        tick();
        FLUSH = 1'b0; IN_VALID = 1'b0;
        #1;
        tests++; if (COUNT !== 2'd0 || OUT_VALID !== 1'b0) begin fails++; $display("FAIL flush_clear: got count=%0d v=%b expected 0 0", COUNT, OUT_VALID); end
        tests++; if (Q !== 8'h11) begin fails++; $display("FAIL flush_data_kept: got %h expected 11", Q); end
        OUT_READY = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            tests++; if (OUT_VALID !== 1'b0) begin fails++; $display("FAIL flush_no_emit c=%0d: got v=%b q=%h expected v=0", c, OUT_VALID, Q); end
        end
    endtask

    task automatic test_reset_mid();
        OUT_READY = 1'b0;
        IN_VALID = 1'b1; D = 8'h44; tick();
        D = 8'h55; tick();
        tests++; if (COUNT !== 2'd2) begin fails++; $display("FAIL rst_mid_pre_count: got %0d expected 2", COUNT); end
        RN = 1'b0; D = 8'h66; FLUSH = 1'b1; tick();
        RN = 1'b1; IN_VALID = 1'b0; FLUSH = 1'b0;
        #1;
        tests++; if (COUNT !== 2'd0 || OUT_VALID !== 1'b0) begin fails++; $display("FAIL rst_mid_clear: got count=%0d v=%b expected 0 0", COUNT, OUT_VALID); end
        tests++; if (Q !== 8'hA5) begin fails++; $display("FAIL rst_mid_q: got %h expected a5", Q); end
        OUT_READY = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            tests++; if (OUT_VALID !== 1'b0) begin fails++; $display("FAIL rst_mid_no_emit c=%0d: got v=%b q=%h expected v=0", c, OUT_VALID, Q); end
        end
    endtask

`ifdef DFF_PIPE_BANK_SCAN_EN
    task automatic test_scan();
        logic [23:0] prior;
        logic [23:0] pat;
        prior = 24'hA51234;
        pat = 24'hC3C3C3;
        RN = 1'b0; tick();
        RN = 1'b1; OUT_READY = 1'b0;
        IN_VALID = 1'b1; D = 8'h12; tick();
        D = 8'h34; tick();
        IN_VALID = 1'b0;
        SE = 1'b1;
        for (int k = 0; k < 24; k++) begin
            SI = pat[23-k];
            #1;
            tests++; if (SO !== prior[23-k]) begin fails++; $display("FAIL scan_so k=%0d: got %b expected %b", k, SO, prior[23-k]); end
            tick();
        end
        tests++; if (IN_READY !== 1'b0 || OUT_VALID !== 1'b0) begin fails++; $display("FAIL scan_handshake: got rdy=%b v=%b expected 0 0", IN_READY, OUT_VALID); end
        tests++; if (COUNT !== 2'd2) begin fails++; $display("FAIL scan_count: got %0d expected 2", COUNT); end
        SE = 1'b0;
        #1;
        tests++; if (Q !== 8'hC3 || OUT_VALID !== 1'b0 || COUNT !== 2'd2) begin fails++; $display("FAIL scan_after: got q=%h v=%b count=%0d expected c3 0 2", Q, OUT_VALID, COUNT); end
    endtask
`endif

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_bubble_flush();
        test_reset_mid();
`ifdef DFF_PIPE_BANK_SCAN_EN
        test_scan();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
